des_round_sequencer: RTL and testbench

//  Sequences the 16 Feistel rounds of one DES pass over a 64-bit block.

---
 rtl/des_pkg.sv | 6 +
 rtl/des_subkey_index.sv | 12 +
 rtl/des_round_sequencer.sv | 64 ++++++
 tb/tb_des_round_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared types and constants for the DES round sequencer and key schedule
package des_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} des_seq_state_t;
  localparam int DES_ROUNDS = 16;
  typedef logic [32:1] des_half_t;
endpackage

// File: rtl/des_subkey_index.sv
// des_subkey_index: maps round number and direction to the subkey number
module des_subkey_index
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS
) (
  input  logic [4:0] round,
  input  logic       mode,
  output logic [4:0] subkey_idx
);
  assign subkey_idx = mode ? 5'(NUM_ROUNDS + 1) - round : round;
endmodule

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: steps the Feistel rounds of one DES pass, folding the external
// round function result into the L/R halves
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [64:1]  in_block,
  input  logic         decrypt,
  output logic [32:1]  f_in,
  output logic [4:0]   subkey_idx,
  input  logic [32:1]  f_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [64:1]  out_block,
  output logic         busy
);
  des_seq_state_t state, state_next;
  logic [4:0] round, idx;
  logic mode;
  des_half_t l, r;
  des_subkey_index #(.NUM_ROUNDS(NUM_ROUNDS)) u_idx (
    .round(round),
    .mode(mode),
    .subkey_idx(idx)
  );
  always_ff @(posedge clk)
    if (!n_rst) begin
      state <= IDLE;
      round <= '0;
      l <= '0;
      r <= '0;
      mode <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        l <= in_block[64:33];
        r <= in_block[32:1];
        mode <= decrypt;
        round <= 5'd1;
      end else if (state == ROUND) begin
        l <= r;
        r <= l ^ f_result;
        round <= round + 5'd1;
      end
    end
  always_comb
    state_next = state == IDLE  ? (in_valid ? ROUND : IDLE) :
                 state == ROUND ? (round == 5'(NUM_ROUNDS) ? DONE : ROUND) :
                 (out_ready ? IDLE : DONE);
  // Data outputs are gated to zero outside the state that owns them
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    f_in = state == ROUND ? r : '0;
    subkey_idx = state == ROUND ? idx : '0;
    out_block = state == DONE ? {r, l} : '0;
  end
endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: scoreboard bench with a stub and a real DES round function
module tb_des_round_sequencer;
  logic clk = 1'b0, n_rst = 1'b0, in_valid = 1'b0, decrypt = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy, use_des = 1'b0;
  logic [64:1] in_block = '0, out_block;
  logic [32:1] f_in, f_result;
  logic [4:0] subkey_idx;
  int pass = 0, total = 0;
  logic [63:0] out_q [$];
  logic [4:0] key_q [$];
  logic [48:1] ks [32];
  int p_t [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                   2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,
                     59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,
                     31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                     29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                     26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                     51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  logic [63:0] sb [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
  localparam logic [64:1] PT = 64'h0123456789ABCDEF, CT = 64'h85E813540F0AB405;

  des_round_sequencer dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .decrypt(decrypt), .f_in(f_in), .subkey_idx(subkey_idx),
    .f_result(f_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [32:1] des_f(input logic [32:1] r, input logic [48:1] k);
    logic [48:1] x;
    logic [32:1] s, o;
    logic [5:0] b;
    logic [63:0] w;
    for (int j = 0; j < 8; j++)
      for (int m = 0; m < 6; m++) x[48-(6*j+m)] = r[32-((4*j+m+31)%32)];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[48-6*j -: 6];
      w = sb[4*j + int'({b[5], b[0]})];
      s[32-4*j -: 4] = w[63-4*b[4:1] -: 4];
    end
    for (int i = 0; i < 32; i++) o[32-i] = s[33-p_t[i]];
    return o;
  endfunction

  function automatic logic [64:1] ip(input logic [64:1] x);
    logic [64:1] o;
    int t;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        t = (r < 4 ? 58 + 2*r : 57 + 2*(r-4)) - 8*c;
        o[64-(8*r+c)] = x[65-t];
      end
    return o;
  endfunction

  assign f_result = use_des ? des_f(f_in, ks[subkey_idx]) : '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: subkey order during ROUND and every accepted output block
  always @(negedge clk)
    if (n_rst) begin
      if (busy && !out_valid && key_q.size() != 0) chk("subkey_idx", 64'(subkey_idx), 64'(key_q.pop_front()));
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) chk("unexpected_out", out_block, 64'hX);
        else chk("out_block", out_block, out_q.pop_front());
      end
    end

  task automatic start(input logic [64:1] blk, input logic dec);
    @(posedge clk); #1;
    in_block = blk; decrypt = dec; in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) begin @(posedge clk); #1; end
    chk("in_ready_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_block = '0; decrypt = 1'b0;
  endtask

  task automatic finish_blk();
    int lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 40);
    chk("latency", 64'(lat), 64'd17);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [64:1] blk, input logic dec, input logic [64:1] exp, input bit keys);
    if (keys) for (int i = 1; i <= 16; i++) key_q.push_back(dec ? 5'(17 - i) : 5'(i));
    out_q.push_back(exp);
    start(blk, dec);
    finish_blk();
  endtask

  initial begin
    logic [64:1] key = 64'h133457799BBCDFF1;
    logic [56:1] cd;
    logic [28:1] c, d;
    for (int i = 0; i < 32; i++) ks[i] = '0;
    for (int i = 0; i < 56; i++) cd[56-i] = key[65-pc1_t[i]];
    c = cd[56:29]; d = cd[28:1];
    for (int n = 1; n <= 16; n++) begin
      repeat ((n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2) begin
        c = {c[27:1], c[28]}; d = {d[27:1], d[28]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][48-i] = cd[57-pc2_t[i]];
    end
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_subkey_idx", 64'(subkey_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_f_in", 64'(f_in), 64'd0);
    chk("rst_out_block", out_block, 64'd0);
    run(64'h0123456789ABCDEF, 1'b0, 64'h89ABCDEF01234567, 1'b0);
    run(64'hFEDCBA9876543210, 1'b0, 64'h76543210FEDCBA98, 1'b1);
    run(64'h0F1E2D3C4B5A6978, 1'b1, 64'h4B5A69780F1E2D3C, 1'b1);
    use_des = 1'b1;
    run(ip(PT), 1'b0, ip(CT), 1'b0);
    run(ip(CT), 1'b1, ip(PT), 1'b0);
    // Backpressure: hold DONE for 10 cycles
    out_ready = 1'b0;
    out_q.push_back(ip(CT));
    start(ip(PT), 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_block", out_block, ip(CT));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_busy", 64'(busy), 64'd0);
    // Reset in the middle of round 7
    start(ip(PT), 1'b0);
    for (int i = 0; i < 40 && subkey_idx != 5'd7; i++) @(negedge clk);
    chk("mid_round7", 64'(subkey_idx), 64'd7);
    n_rst = 1'b0;
    @(posedge clk); #1 n_rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_subkey_idx", 64'(subkey_idx), 64'd0);
    repeat (20) @(negedge clk);
    run(ip(CT), 1'b1, ip(PT), 1'b1);
    repeat (3) @(negedge clk);
    chk("out_q_drained", 64'(out_q.size()), 64'd0);
    chk("key_q_drained", 64'(key_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
